// File: rtl/imem_program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The master side drives the stream and reload; the slave side is the loader.
interface imem_program_loader_if #(
   parameter int ADDR_W = 10
);
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              reload;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              core_rst;
   logic              done;
   logic              error;

   modport master (
      output in_valid, in_data, reload,
      input  in_ready, imem_we, imem_addr, imem_wdata, core_rst, done, error
   );

   modport slave (
      input  in_valid, in_data, reload,
      output in_ready, imem_we, imem_addr, imem_wdata, core_rst, done, error
   );
endinterface

// File: rtl/imem_program_loader.sv
// Receives a framed program image (LEN_HI, LEN_LO, N big-endian words, XOR checksum)
// and writes it into instruction memory, holding the core in reset until it verifies.
//
// state    | meaning
// S_LEN_HI | waiting for the high byte of the word count
// S_LEN_LO | waiting for the low byte; range-checks the count
// S_DATA   | assembling payload bytes into words and writing them
// S_CSUM   | comparing the received checksum byte with the running XOR
// S_DONE   | image verified, core released; waits for reload
// S_ERR    | bad length or checksum, core held; waits for reload
module imem_program_loader #(
   parameter int ADDR_W = 10
) (
   input logic                  clk,
   input logic                  rst,
   imem_program_loader_if.slave bus
);
   typedef enum logic [2:0] {
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

   state_t            state, state_nxt;
   logic [7:0]        len_hi, len_hi_nxt;
   logic [15:0]       len, len_nxt;
   logic [1:0]        byte_cnt, byte_cnt_nxt;
   logic [23:0]       asm_q, asm_nxt;
   logic [ADDR_W:0]   word_idx, word_idx_nxt;
   logic [7:0]        csum, csum_nxt;
   logic              we, we_nxt;
   logic [ADDR_W-1:0] addr, addr_nxt;
   logic [31:0]       wdata, wdata_nxt;
   logic              core_rst, done, error;
   logic              ready, xfer, last_word;
   logic [15:0]       len_in;

   assign ready     = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                      (state == S_DATA)   || (state == S_CSUM);
   assign xfer      = bus.in_valid && ready;
   assign len_in    = {len_hi, bus.in_data};
   // word_idx is one bit wider than the address so a full 2**ADDR_W image compares cleanly
   assign last_word = ((17'(word_idx) + 17'd1) == {1'b0, len});

   always_comb begin
      state_nxt    = state;
      len_hi_nxt   = len_hi;
      len_nxt      = len;
      byte_cnt_nxt = byte_cnt;
      asm_nxt      = asm_q;
      word_idx_nxt = word_idx;
      csum_nxt     = csum;
      we_nxt       = 1'b0;
      addr_nxt     = addr;
      wdata_nxt    = wdata;
      case (state)
         S_LEN_HI: begin
            if (xfer) begin
               len_hi_nxt = bus.in_data;
               csum_nxt   = csum ^ bus.in_data;
               state_nxt  = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (xfer) begin
               len_nxt  = len_in;
               csum_nxt = csum ^ bus.in_data;
               if ({1'b0, len_in} > MAX_WORDS) begin
                  state_nxt = S_ERR;
               end else if (len_in == 16'd0) begin
                  state_nxt = S_CSUM;
               end else begin
                  state_nxt = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (xfer) begin
               csum_nxt     = csum ^ bus.in_data;
               byte_cnt_nxt = byte_cnt + 2'd1;
               asm_nxt      = {asm_q[15:0], bus.in_data};
               if (byte_cnt == 2'd3) begin
                  we_nxt       = 1'b1;
                  addr_nxt     = word_idx[ADDR_W-1:0];
                  wdata_nxt    = {asm_q, bus.in_data};
                  word_idx_nxt = word_idx + 1'b1;
                  if (last_word) begin
                     state_nxt = S_CSUM;
                  end
               end
            end
         end
         S_CSUM: begin
            if (xfer) begin
               state_nxt = (bus.in_data == csum) ? S_DONE : S_ERR;
            end
         end
         S_DONE, S_ERR: begin
            if (bus.reload) begin
               state_nxt    = S_LEN_HI;
               csum_nxt     = 8'd0;
               word_idx_nxt = '0;
               byte_cnt_nxt = 2'd0;
            end
         end
         default: state_nxt = S_LEN_HI;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_LEN_HI;
         len_hi   <= 8'd0;
         len      <= 16'd0;
         byte_cnt <= 2'd0;
         asm_q    <= 24'd0;
         word_idx <= '0;
         csum     <= 8'd0;
         we       <= 1'b0;
         addr     <= '0;
         wdata    <= 32'd0;
         core_rst <= 1'b1;
         done     <= 1'b0;
         error    <= 1'b0;
      end else begin
         state    <= state_nxt;
         len_hi   <= len_hi_nxt;
         len      <= len_nxt;
         byte_cnt <= byte_cnt_nxt;
         asm_q    <= asm_nxt;
         word_idx <= word_idx_nxt;
         csum     <= csum_nxt;
         we       <= we_nxt;
         addr     <= addr_nxt;
         wdata    <= wdata_nxt;
         core_rst <= (state_nxt != S_DONE);
         done     <= (state_nxt == S_DONE);
         error    <= (state_nxt == S_ERR);
      end
   end

   assign bus.in_ready   = ready;
   assign bus.imem_we    = we;
   assign bus.imem_addr  = addr;
   assign bus.imem_wdata = wdata;
   assign bus.core_rst   = core_rst;
   assign bus.done       = done;
   assign bus.error      = error;
endmodule

// File: tb/tb_imem_program_loader.sv
// Bench for imem_program_loader: frames are built from random words, and expected
// writes and status come from the frame rules (word list, XOR checksum, length limit).
module tb_imem_program_loader;
   localparam int ADDR_W = 10;
   localparam int DEPTH  = 1 << ADDR_W;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   imem_program_loader_if #(.ADDR_W(ADDR_W)) bus ();
   imem_program_loader #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_cmp = 0;
   int n_err = 0;
   int unsigned exp_addr[$];
   logic [31:0] exp_data[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // every observed write must be the next one the model expects
   always @(negedge clk) begin
      if (rst === 1'b0 && bus.imem_we === 1'b1) begin
         if (exp_addr.size() == 0) begin
            check("unexpected_write", 64'(exp_addr.size()), 64'd1);
         end else begin
            check("wr_addr", 64'(bus.imem_addr), 64'(exp_addr.pop_front()));
            check("wr_data", 64'(bus.imem_wdata), 64'(exp_data.pop_front()));
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int max_gap);
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      if (gap > 0) begin
         bus.in_valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      for (int t = 0; t < 50; t++) begin
         if (bus.in_ready) begin
            @(negedge clk);
            return;
         end
         @(negedge clk);
      end
      check("byte_timeout", 64'(bus.in_ready), 64'd1);
   endtask

   // corrupt != 0 flips checksum bits; a valid image must end in DONE
   task automatic send_frame(input logic [31:0] words[$], input logic [7:0] corrupt,
                             input int max_gap);
      logic [7:0] q[$];
      logic [7:0] cs;
      int n;
      n = words.size();
      q.push_back(8'(n >> 8));
      q.push_back(8'(n));
      for (int i = 0; i < n; i++) begin
         q.push_back(words[i][31:24]);
         q.push_back(words[i][23:16]);
         q.push_back(words[i][15:8]);
         q.push_back(words[i][7:0]);
         exp_addr.push_back(i);
         exp_data.push_back(words[i]);
      end
      cs = 8'd0;
      foreach (q[i]) cs ^= q[i];
      q.push_back(cs ^ corrupt);
      foreach (q[i]) send_byte(q[i], max_gap);
      bus.in_valid = 1'b0;
      check("done", 64'(bus.done), 64'(corrupt == 8'd0));
      check("error", 64'(bus.error), 64'(corrupt != 8'd0));
      check("core_rst", 64'(bus.core_rst), 64'(corrupt != 8'd0));
      check("ready_idle", 64'(bus.in_ready), 64'd0);
      check("writes_pending", 64'(exp_addr.size()), 64'd0);
   endtask

   task automatic do_reload(input logic with_byte);
      bus.reload   = 1'b1;
      bus.in_valid = with_byte;
      bus.in_data  = 8'hA5;
      @(negedge clk);
      bus.reload   = 1'b0;
      bus.in_valid = 1'b0;
      check("rl_core_rst", 64'(bus.core_rst), 64'd1);
      check("rl_done", 64'(bus.done), 64'd0);
      check("rl_error", 64'(bus.error), 64'd0);
      check("rl_ready", 64'(bus.in_ready), 64'd1);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_we"}, 64'(bus.imem_we), 64'd0);
      check({tag, "_addr"}, 64'(bus.imem_addr), 64'd0);
      check({tag, "_wdata"}, 64'(bus.imem_wdata), 64'd0);
      check({tag, "_core_rst"}, 64'(bus.core_rst), 64'd1);
      check({tag, "_done"}, 64'(bus.done), 64'd0);
      check({tag, "_error"}, 64'(bus.error), 64'd0);
      check({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
   endtask

   function automatic void rand_words(output logic [31:0] w[$], input int n);
      w = {};
      for (int i = 0; i < n; i++) w.push_back($urandom);
   endfunction

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] w[$];
      logic [7:0]  bad;
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      bus.reload   = 1'b0;
      #1;
      check_reset_values("por");
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // minimal image, then bad checksum of the same image (0x09 ^ 0x09 = 0x00)
      w = {32'h12345678};
      send_frame(w, 8'h00, 0);
      do_reload(1'b0);
      send_frame(w, 8'h09, 0);
      do_reload(1'b0);

      // length above memory depth
      send_byte(8'h04, 0);
      send_byte(8'h01, 0);
      bus.in_valid = 1'b0;
      check("len_err_error", 64'(bus.error), 64'd1);
      check("len_err_core_rst", 64'(bus.core_rst), 64'd1);
      check("len_err_ready", 64'(bus.in_ready), 64'd0);
      do_reload(1'b0);

      // empty image and full-depth image
      w = {};
      send_frame(w, 8'h00, 0);
      do_reload(1'b0);
      rand_words(w, DEPTH);
      send_frame(w, 8'h00, 0);
      do_reload(1'b0);

      // gaps on in_valid, then bytes offered while DONE must not be taken
      rand_words(w, 3);
      send_frame(w, 8'h00, 4);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h55;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("done_hold_ready", 64'(bus.in_ready), 64'd0);
         check("done_hold_done", 64'(bus.done), 64'd1);
      end

      // reload with a simultaneous byte; the next image must load from address 0
      do_reload(1'b1);
      rand_words(w, 2);
      send_frame(w, 8'h00, 0);
      do_reload(1'b0);

      // reset after two bytes of word 1
      rand_words(w, 2);
      send_byte(8'h00, 0);
      send_byte(8'h02, 0);
      exp_addr.push_back(0);
      exp_data.push_back(w[0]);
      for (int b = 3; b >= 0; b--) send_byte(8'(w[0] >> (8 * b)), 0);
      send_byte(w[1][31:24], 0);
      send_byte(w[1][23:16], 0);
      bus.in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check_reset_values("mid_rst");
      check("mid_rst_pending", 64'(exp_addr.size()), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      rand_words(w, 4);
      send_frame(w, 8'h00, 1);
      do_reload(1'b0);

      // random images, some with corrupted checksums
      for (int r = 0; r < 8; r++) begin
         rand_words(w, int'($urandom_range(8, 1)));
         bad = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
         send_frame(w, bad, 3);
         do_reload(1'($urandom_range(1, 0)));
      end

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
